op_sequencer: RTL and testbench

- Issue side of the matrix ALU opcode interface: buffers a program of 4-bit opcodes and presents them one at a time on the opcode bus driving the control unit.
- Holds each opcode stable until the datapath signals completion, then advances.
- Skips nop and illegal codes, flags illegal codes and hung operations, and reports program completion.

---
 rtl/op_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_op_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/op_sequencer.sv
// op_sequencer: issue side of the matrix ALU opcode interface.
// Buffers a program of 4-bit opcodes in a small FIFO. The opcodes are presented
// one at a time on the opcode bus. Each opcode is held until the datapath reports
// completion. Nops and illegal codes are skipped, and hung operations are aborted.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   in_valid        - program write request
//   in_opcode[3:0]  - opcode to enqueue
//   in_ready        - FIFO can accept a write
//   start           - begin executing the buffered program (IDLE only)
//   opcode[3:0]     - opcode bus to the control unit (nop outside ISSUE/WAIT)
//   op_valid        - one-cycle strobe marking a newly issued opcode
//   op_done         - datapath completion pulse for the current opcode
//   busy            - sequencer not in IDLE
//   prog_done       - one-cycle pulse when the program drains normally
//   illegal_err     - sticky: an opcode in 0100..0111 was fetched
//   timeout_err     - sticky: an operation exceeded TIMEOUT wait cycles
//   issued_count    - legal non-nop opcodes completed (wraps)
module op_sequencer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_opcode,
  output logic             in_ready,
  input  logic             start,
  output logic [3:0]       opcode,
  output logic             op_valid,
  input  logic             op_done,
  output logic             busy,
  output logic             prog_done,
  output logic             illegal_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] issued_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t         state;
  logic [3:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  logic [TW-1:0]  tmo_cnt;
  logic           wr;
  logic           pop;
  logic [3:0]     head;

  // 0100..0111 are the only illegal codes.
  function automatic logic is_illegal(input logic [3:0] op);
    return op[3:2] == 2'b01;
  endfunction

  assign wr   = in_valid && in_ready;
  assign pop  = (state == FETCH) && (count != '0);
  assign head = mem[rd_ptr];

  // FIFO occupancy after this cycle's write and pop.
  always_comb begin
    count_next = count;
    case ({wr, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Program storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= in_opcode;
  end

  // FIFO pointers, sequencer state and all registered outputs.
  // The opcode register doubles as the current-op holder in ISSUE/WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      tmo_cnt      <= '0;
      in_ready     <= 1'b1;
      opcode       <= 4'b0000;
      op_valid     <= 1'b0;
      busy         <= 1'b0;
      prog_done    <= 1'b0;
      illegal_err  <= 1'b0;
      timeout_err  <= 1'b0;
      issued_count <= '0;
    end else begin
      count     <= count_next;
      in_ready  <= (count_next < CW'(DEPTH));
      op_valid  <= 1'b0;
      prog_done <= 1'b0;
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case (state)
        IDLE: begin
          if (start && (count != '0)) begin
            state       <= FETCH;
            busy        <= 1'b1;
            illegal_err <= 1'b0;
            timeout_err <= 1'b0;
          end
        end

        FETCH: begin
          if (pop) begin
            if (is_illegal(head)) illegal_err <= 1'b1;
            if (!is_illegal(head) && (head != 4'b0000)) begin
              state    <= ISSUE;
              opcode   <= head;
              op_valid <= 1'b1;
            end else if (count_next == '0) begin
              // Skipped the last entry: program complete.
              state     <= IDLE;
              busy      <= 1'b0;
              prog_done <= 1'b1;
            end
          end else begin
            // Unreachable by construction; recover to IDLE.
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        ISSUE: begin
          // op_done is deliberately not looked at here.
          state   <= WAIT;
          tmo_cnt <= '0;
        end

        WAIT: begin
          if (op_done) begin
            issued_count <= issued_count + CNT_W'(1);
            opcode       <= 4'b0000;
            // A write landing this cycle keeps the program going.
            if (count_next != '0) begin
              state <= FETCH;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              prog_done <= 1'b1;
            end
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            // Hung operation: abort, keep the remaining program.
            timeout_err <= 1'b1;
            opcode      <= 4'b0000;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          opcode <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: directed self-checking bench for op_sequencer.
// Expected issue order is queued as programs are written and checked as
// op_valid strobes appear; op_done is answered one cycle after each strobe.
module tb_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_opcode;
  logic       in_ready;
  logic       start;
  logic [3:0] opcode;
  logic       op_valid;
  logic       op_done;
  logic       busy;
  logic       prog_done;
  logic       illegal_err;
  logic       timeout_err;
  logic [7:0] issued_count;

  op_sequencer #(.DEPTH(8), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_opcode    (in_opcode),
    .in_ready     (in_ready),
    .start        (start),
    .opcode       (opcode),
    .op_valid     (op_valid),
    .op_done      (op_done),
    .busy         (busy),
    .prog_done    (prog_done),
    .illegal_err  (illegal_err),
    .timeout_err  (timeout_err),
    .issued_count (issued_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests;
  int         fails;
  int         exp_issued;
  logic [3:0] sb [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic write_op(input logic [3:0] op);
    @(negedge clk);
    in_valid  = 1'b1;
    in_opcode = op;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observe one negedge per cycle until the sequencer goes idle.
  task automatic run(input int budget, input bit respond, input bit inject,
                     input logic [3:0] inj_op,
                     output int n_valid, output int n_pd, output int n_wait);
    bit         pending;
    bit         finished;
    int         fetches;
    logic [3:0] exp_op;
    pending  = 1'b0;
    finished = 1'b0;
    fetches  = 0;
    n_valid  = 0;
    n_pd     = 0;
    n_wait   = 0;
    for (int c = 0; c < budget && !finished; c++) begin
      op_done  = pending;
      pending  = 1'b0;
      in_valid = 1'b0;
      if (prog_done) n_pd++;
      if (op_valid) begin
        n_valid++;
        pending = respond;
        if (sb.size() == 0) begin
          chk("sb_unexpected_issue", 32'(opcode), 32'hFF);
        end else begin
          exp_op = sb.pop_front();
          chk("issued_opcode", 32'(opcode), 32'(exp_op));
        end
      end else if (busy && opcode != 4'b0000) begin
        n_wait++;
      end else if (busy) begin
        fetches++;
        if (inject && fetches == 2) begin
          in_valid  = 1'b1;
          in_opcode = inj_op;
          sb.push_back(inj_op);
        end
      end
      if (!busy) finished = 1'b1;
      else @(negedge clk);
    end
    op_done  = 1'b0;
    in_valid = 1'b0;
    if (!finished) chk("run_cycle_budget", 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (op_valid) seen = 1'b1;
    end
    if (!seen) chk("wait_op_valid", 32'(op_valid), 32'd1);
  endtask

  int nv, npd, nw;

  initial begin
    tests      = 0;
    fails      = 0;
    exp_issued = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_opcode  = 4'h0;
    start      = 1'b0;
    op_done    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_in_ready",  32'(in_ready),     32'd1);
    chk("rst_opcode",    32'(opcode),       32'd0);
    chk("rst_op_valid",  32'(op_valid),     32'd0);
    chk("rst_busy",      32'(busy),         32'd0);
    chk("rst_prog_done", 32'(prog_done),    32'd0);
    chk("rst_illegal",   32'(illegal_err),  32'd0);
    chk("rst_timeout",   32'(timeout_err),  32'd0);
    chk("rst_issued",    32'(issued_count), 32'd0);
    rst_n = 1'b1;

    // Basic program: mult, add, shift/logic.
    write_op(4'h1); sb.push_back(4'h1);
    write_op(4'h2); sb.push_back(4'h2);
    write_op(4'hD); sb.push_back(4'hD);
    pulse_start();
    run(100, 1'b1, 1'b0, 4'h0, nv, npd, nw);
    exp_issued += 3;
    chk("t1_valid_pulses", 32'(nv),           32'd3);
    chk("t1_prog_done",    32'(npd),          32'd1);
    chk("t1_issued",       32'(issued_count), 32'(exp_issued));
    chk("t1_busy",         32'(busy),         32'd0);
    chk("t1_in_ready",     32'(in_ready),     32'd1);
    chk("t1_sb_drained",   32'(sb.size()),    32'd0);

    // Nop and illegal codes are skipped; illegal is flagged.
    write_op(4'h0);
    write_op(4'h5);
    write_op(4'h3); sb.push_back(4'h3);
    pulse_start();
    run(100, 1'b1, 1'b0, 4'h0, nv, npd, nw);
    exp_issued += 1;
    chk("t2_valid_pulses", 32'(nv),           32'd1);
    chk("t2_prog_done",    32'(npd),          32'd1);
    chk("t2_illegal",      32'(illegal_err),  32'd1);
    chk("t2_issued",       32'(issued_count), 32'(exp_issued));

    // Timeout with op_done held low; the remaining entry is kept.
    write_op(4'h8); sb.push_back(4'h8);
    write_op(4'h2); sb.push_back(4'h2);
    pulse_start();
    chk("t3_start_clears_illegal", 32'(illegal_err), 32'd0);
    run(100, 1'b0, 1'b0, 4'h0, nv, npd, nw);
    chk("t3_wait_cycles",  32'(nw),           32'd4);
    chk("t3_timeout_err",  32'(timeout_err),  32'd1);
    chk("t3_opcode_nop",   32'(opcode),       32'd0);
    chk("t3_busy",         32'(busy),         32'd0);
    chk("t3_no_prog_done", 32'(npd),          32'd0);
    chk("t3_issued",       32'(issued_count), 32'(exp_issued));
    pulse_start();
    chk("t3_start_clears_timeout", 32'(timeout_err), 32'd0);
    run(100, 1'b1, 1'b0, 4'h0, nv, npd, nw);
    exp_issued += 1;
    chk("t3_retained_issued", 32'(nv),           32'd1);
    chk("t3_retained_count",  32'(issued_count), 32'(exp_issued));

    // Fill, drop a write on full, then write during a FETCH pop.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ops [8];
      ops = '{4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
      write_op(ops[i]);
      sb.push_back(ops[i]);
    end
    chk("t4_full_in_ready", 32'(in_ready), 32'd0);
    write_op(4'hF);
    pulse_start();
    run(300, 1'b1, 1'b1, 4'hE, nv, npd, nw);
    exp_issued += 9;
    chk("t4_valid_pulses", 32'(nv),           32'd9);
    chk("t4_prog_done",    32'(npd),          32'd1);
    chk("t4_issued",       32'(issued_count), 32'(exp_issued));
    chk("t4_sb_drained",   32'(sb.size()),    32'd0);
    chk("t4_in_ready",     32'(in_ready),     32'd1);

    // op_done during ISSUE only is ignored.
    write_op(4'h1);
    pulse_start();
    wait_valid(20);
    chk("t6_issue_opcode", 32'(opcode), 32'd1);
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    chk("t6_still_busy",   32'(busy),     32'd1);
    chk("t6_held_opcode",  32'(opcode),   32'd1);
    chk("t6_no_revalid",   32'(op_valid), 32'd0);
    @(negedge clk);
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    exp_issued += 1;
    chk("t6_done_busy",    32'(busy),         32'd0);
    chk("t6_prog_done",    32'(prog_done),    32'd1);
    chk("t6_issued",       32'(issued_count), 32'(exp_issued));

    // Reset during WAIT of a mult aborts immediately and empties the FIFO.
    write_op(4'h1);
    write_op(4'h2);
    pulse_start();
    wait_valid(20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_issued = 0;
    chk("t5_opcode",   32'(opcode),       32'd0);
    chk("t5_busy",     32'(busy),         32'd0);
    chk("t5_op_valid", 32'(op_valid),     32'd0);
    chk("t5_in_ready", 32'(in_ready),     32'd1);
    chk("t5_issued",   32'(issued_count), 32'(exp_issued));
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    chk("t5_start_ignored", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t5_still_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
